// File: rtl/ula_mc_control_if.sv
// ULA-facing bundle of the multicycle control:
// operation select, operand muxes and the Z flag.
interface ula_mc_control_if;
  logic [3:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       ext_zero;
  logic       zero;

  modport master (
    output alu_op, alu_src_a, alu_src_b, ext_zero,
    input  zero
  );

  modport slave (
    input  alu_op, alu_src_a, alu_src_b, ext_zero,
    output zero
  );
endinterface

// File: rtl/ula_mc_control.sv
// Multicycle MIPS control FSM: decodes IR fields,
// drives the ULA select and all datapath enables.
module ula_mc_control #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  ula_mc_control_if.master ula,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       pc_write,
  output logic [1:0] pc_source,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    I_EXEC    = 4'd10,
    I_WB      = 4'd11
  } state_t;

  state_t     cur;
  state_t     nxt;
  state_t     dec_nxt;
  logic       dec_bad;
  logic       rdy;
  logic [3:0] r_alu;
  logic       r_ok;
  logic [3:0] i_alu;
  logic       i_ext;
  logic [3:0] op_hold;
  logic       ext_hold;
  logic       is_sw;
  logic       is_bne;

  assign rdy   = MEM_WAIT_EN ? mem_ready : 1'b1;
  assign state = cur;

  always_comb begin
    dec_nxt = FETCH;
    dec_bad = 1'b0;
    case (opcode)
      6'b000000: dec_nxt = R_EXEC;
      6'b100011,
      6'b101011: dec_nxt = MEM_ADDR;
      6'b000100,
      6'b000101: dec_nxt = BRANCH;
      6'b000010: dec_nxt = JUMP;
      6'b001000,
      6'b001001,
      6'b001100,
      6'b001101,
      6'b001110,
      6'b001010: dec_nxt = I_EXEC;
      default:   dec_bad = 1'b1;
    endcase
  end

  always_comb begin
    r_alu = 4'b0000;
    r_ok  = 1'b1;
    case (funct)
      6'b100000: r_alu = 4'b0010;
      6'b100001: r_alu = 4'b0100;
      6'b100010: r_alu = 4'b0110;
      6'b100011: r_alu = 4'b0101;
      6'b100100: r_alu = 4'b0000;
      6'b100101: r_alu = 4'b0001;
      6'b100110: r_alu = 4'b0011;
      6'b100111: r_alu = 4'b1100;
      6'b101010: r_alu = 4'b0111;
      default:   r_ok  = 1'b0;
    endcase
  end

  always_comb begin
    i_alu = 4'b0010;
    i_ext = 1'b0;
    case (opcode)
      6'b001001: i_alu = 4'b0100;
      6'b001100: begin i_alu = 4'b0000; i_ext = 1'b1; end
      6'b001101: begin i_alu = 4'b0001; i_ext = 1'b1; end
      6'b001110: begin i_alu = 4'b0011; i_ext = 1'b1; end
      6'b001010: i_alu = 4'b0111;
      default:   i_alu = 4'b0010;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur      <= FETCH;
      illegal  <= 1'b0;
      op_hold  <= 4'b0000;
      ext_hold <= 1'b0;
      is_sw    <= 1'b0;
      is_bne   <= 1'b0;
    end else begin
      cur     <= nxt;
      illegal <= (cur == DECODE && dec_bad) ||
                 (cur == R_EXEC && !r_ok);
      if (cur == DECODE) begin
        is_sw  <= (opcode == 6'b101011);
        is_bne <= (opcode == 6'b000101);
      end
      if (cur == R_EXEC) begin
        op_hold  <= r_ok ? r_alu : 4'b0000;
        ext_hold <= 1'b0;
      end
      if (cur == I_EXEC) begin
        op_hold  <= i_alu;
        ext_hold <= i_ext;
      end
    end
  end

  // Outputs forced low while reset is held
  always_comb begin
    nxt           = FETCH;
    ula.alu_op    = 4'b0000;
    ula.alu_src_a = 1'b0;
    ula.alu_src_b = 2'd0;
    ula.ext_zero  = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    pc_write      = 1'b0;
    pc_source     = 2'd0;
    if (rst_n) begin
      case (cur)
        FETCH: begin
          mem_read      = 1'b1;
          ula.alu_src_b = 2'd1;
          ula.alu_op    = 4'b0010;
          ir_write      = rdy;
          pc_write      = rdy;
          nxt           = rdy ? DECODE : FETCH;
        end
        DECODE: begin
          ula.alu_src_b = 2'd3;
          ula.alu_op    = 4'b0010;
          nxt           = dec_nxt;
        end
        MEM_ADDR: begin
          ula.alu_src_a = 1'b1;
          ula.alu_src_b = 2'd2;
          ula.alu_op    = 4'b0010;
          nxt           = is_sw ? MEM_WRITE : MEM_READ;
        end
        MEM_READ: begin
          mem_read = 1'b1;
          iord     = 1'b1;
          nxt      = rdy ? MEM_WB : MEM_READ;
        end
        MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        MEM_WRITE: begin
          mem_write = 1'b1;
          iord      = 1'b1;
          nxt       = rdy ? FETCH : MEM_WRITE;
        end
        R_EXEC: begin
          ula.alu_src_a = 1'b1;
          ula.alu_op    = r_ok ? r_alu : 4'b0000;
          nxt           = r_ok ? R_WB : FETCH;
        end
        R_WB: begin
          reg_write  = 1'b1;
          reg_dst    = 1'b1;
          ula.alu_op = op_hold;
        end
        BRANCH: begin
          ula.alu_src_a = 1'b1;
          ula.alu_op    = 4'b0110;
          pc_source     = 2'd1;
          pc_write      = is_bne ? ~ula.zero : ula.zero;
        end
        JUMP: begin
          pc_write  = 1'b1;
          pc_source = 2'd2;
        end
        I_EXEC: begin
          ula.alu_src_a = 1'b1;
          ula.alu_src_b = 2'd2;
          ula.alu_op    = i_alu;
          ula.ext_zero  = i_ext;
          nxt           = I_WB;
        end
        I_WB: begin
          reg_write     = 1'b1;
          ula.alu_src_a = 1'b1;
          ula.alu_src_b = 2'd2;
          ula.alu_op    = op_hold;
          ula.ext_zero  = ext_hold;
        end
        default: nxt = FETCH;
      endcase
    end
  end

endmodule

// File: doc/ula_mc_control.md
Name: ula_mc_control

Overview:
- Multicycle control FSM for the 32-bit MIPS datapath; it is the initiator side of the ULA interface.
- Decodes the instruction register fields and drives the ULA operation select (alu_op) plus all datapath enables.
- Consumes the ULA zero flag to resolve BEQ/BNE.
- Stalls on a memory ready handshake; sits between the instruction register and the datapath muxes/enables.

Parameters:
- MEM_WAIT_EN, 1, 1 = memory states hold until mem_ready is high; 0 = mem_ready ignored, memory assumed single-cycle.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0]
- zero  in  1  ULA Z flag, sampled in BRANCH
- mem_ready  in  1  memory access completes this cycle
- alu_op  out  4  ULA operation select
- alu_src_a  out  1  0 = PC, 1 = reg A
- alu_src_b  out  2  0 = reg B, 1 = constant 4, 2 = extended imm, 3 = extended imm << 2
- ext_zero  out  1  1 = zero-extend imm, 0 = sign-extend
- iord  out  1  memory address from ALUOut (1) or PC (0)
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  load IR
- reg_write  out  1  register file write
- reg_dst  out  1  1 = rd, 0 = rt
- mem_to_reg  out  1  1 = MDR, 0 = ALUOut
- pc_write  out  1  PC load, with branch condition already resolved
- pc_source  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target
- illegal  out  1  one-cycle pulse on unsupported opcode/funct
- state  out  4  current state, for debug

Behaviour:
- Reset, asynchronous on rst_n low:
  - state = FETCH (0); all outputs 0.
  - Exception: FETCH outputs are Moore-decoded from state, so they appear as soon as reset deasserts.
- Unlisted outputs are 0 in every state.
- Encodings: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11.
- FETCH:
  - Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=0010, pc_source=0.
  - ir_write=pc_write=mem_ready (or 1 when MEM_WAIT_EN=0).
  - Holds until ready, then goes to DECODE.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=3, alu_op=0010 (branch target precompute).
  - Next state by opcode:
    - 000000 → R_EXEC
    - 100011 (LW) and 101011 (SW) → MEM_ADDR
    - 000100 (BEQ) and 000101 (BNE) → BRANCH
    - 000010 (J) → JUMP
    - 001000, 001001, 001100, 001101, 001110, 001010 → I_EXEC
    - other → FETCH with illegal=1 for one cycle
- MEM_ADDR: alu_src_a=1, alu_src_b=2, ext_zero=0, alu_op=0010. Next: LW → MEM_READ, SW → MEM_WRITE.
- MEM_READ: mem_read=1, iord=1. Holds until ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next: FETCH.
- MEM_WRITE: mem_write=1, iord=1. Holds until ready, then FETCH.
- R_EXEC:
  - alu_src_a=1, alu_src_b=0; alu_op by funct:
    - 100000 ADD → 0010
    - 100001 ADDU → 0100
    - 100010 SUB → 0110
    - 100011 SUBU → 0101
    - 100100 AND → 0000
    - 100101 OR → 0001
    - 100110 XOR → 0011
    - 100111 NOR → 1100
    - 101010 SLT → 0111
  - SLTU and any other funct: illegal pulse, alu_op=0000, next FETCH, no writeback.
  - Legal funct: next R_WB.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0, alu_op held from R_EXEC. Next: FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=0, alu_op=0110, pc_source=1.
  - pc_write = zero for BEQ, ~zero for BNE.
  - Next: FETCH.
- JUMP: pc_write=1, pc_source=2. Next: FETCH.
- I_EXEC:
  - alu_src_a=1, alu_src_b=2.
  - ADDI → 0010, sign-extend
  - ADDIU → 0100, sign-extend
  - ANDI → 0000, ext_zero=1
  - ORI → 0001, ext_zero=1
  - XORI → 0011, ext_zero=1
  - SLTI → 0111, sign-extend
  - Next: I_WB.
- I_WB: reg_write=1, reg_dst=0, mem_to_reg=0, alu_op/alu_src/ext_zero held. Next: FETCH.
- Timing: outputs are decoded from state only (Moore); pc_write in FETCH/BRANCH and ir_write in FETCH are the only input-dependent outputs.
- Per-instruction latency with memory ready every cycle: R=4, I=4, LW=5, SW=4, BEQ/BNE=3, J=3, illegal=2.
- Boundary conditions:
  - mem_ready low indefinitely: state and all strobes held, no PC/IR update.
  - rst_n asserted mid-instruction: immediate return to FETCH, no partial writeback.
  - opcode/funct changing outside DECODE/R_EXEC/I_EXEC: ignored.
  - Undefined state code: next FETCH.

Test Plan:
- Reset low 3 cycles, release with mem_ready=1 → state=0 then 1; first FETCH asserts ir_write=1, pc_write=1, alu_op=0010.
- opcode=000000, funct=100010 (SUB) → states 0,1,6,7,0; alu_op=0110 in state 6; reg_write=1, reg_dst=1 only in state 7.
- LW (100011) with mem_ready low 2 cycles in MEM_READ → state 3 held 3 cycles with mem_read=1, iord=1; then state 4 with reg_write=1, mem_to_reg=1.
- BEQ: zero=1 → pc_write=1, pc_source=1 in BRANCH; BNE with zero=1 → pc_write=0; BNE with zero=0 → pc_write=1.
- ORI (001101) → ext_zero=1, alu_op=0001, alu_src_b=2 in states 10 and 11; reg_write=1 only in 11.
- Illegal cases:
  - opcode=111111 → illegal=1 in the cycle after DECODE, back in FETCH, reg_write never asserted.
  - funct=101011 → same result via R_EXEC.
  - rst_n pulsed low during R_EXEC → state=0 asynchronously, no R_WB.
